// File: rtl/axi4_txn_monitor_if.sv
// AXI4 bus interface with a passive monitor modport.
// All channel signals are visible to the monitor as inputs only.
interface axi4_if #(
  parameter int AXI4_ADDRESS_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH    = 32,
  parameter int AXI4_ID_WIDTH      = 4
) ();
  logic [AXI4_ID_WIDTH-1:0]        awid;
  logic [AXI4_ADDRESS_WIDTH-1:0]   awaddr;
  logic [7:0]                      awlen;
  logic                            awvalid;
  logic                            awready;
  logic [AXI4_DATA_WIDTH-1:0]      wdata;
  logic [AXI4_DATA_WIDTH/8-1:0]    wstrb;
  logic                            wlast;
  logic                            wvalid;
  logic                            wready;
  logic [AXI4_ID_WIDTH-1:0]        bid;
  logic [1:0]                      bresp;
  logic                            bvalid;
  logic                            bready;
  logic [AXI4_ID_WIDTH-1:0]        arid;
  logic [AXI4_ADDRESS_WIDTH-1:0]   araddr;
  logic [7:0]                      arlen;
  logic                            arvalid;
  logic                            arready;
  logic [AXI4_ID_WIDTH-1:0]        rid;
  logic [AXI4_DATA_WIDTH-1:0]      rdata;
  logic [1:0]                      rresp;
  logic                            rlast;
  logic                            rvalid;
  logic                            rready;

  modport monitor (
    input awid, awaddr, awlen, awvalid, awready,
    input wdata, wstrb, wlast, wvalid, wready,
    input bid, bresp, bvalid, bready,
    input arid, araddr, arlen, arvalid, arready,
    input rid, rdata, rresp, rlast, rvalid, rready
  );
endinterface

// File: rtl/axi4_txn_monitor.sv
// Passive AXI4 transaction monitor / protocol checker.
// Tracks outstanding bursts, counts completions, checks WLAST against AWLEN
// and latches the first violation in a sticky error register.
// Optional watchdog enabled by defining AXI4_TXN_MONITOR_TIMEOUT_EN.
// Handshake semantics: a transfer happens on a rising edge where VALID and
// READY are both 1; the monitor only samples, it never drives the bus.
module axi4_txn_monitor #(
  parameter int AXI4_ADDRESS_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH    = 32,
  parameter int AXI4_ID_WIDTH      = 4,
  parameter int MAX_OUTSTANDING    = 8,
  parameter int CNT_WIDTH          = 32,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                               clk,
  input  logic                               rst,
  axi4_if.monitor                            monitor,
  input  logic                               clr,
  output logic [$clog2(MAX_OUTSTANDING):0]   wr_outstanding,
  output logic [$clog2(MAX_OUTSTANDING):0]   rd_outstanding,
  output logic [CNT_WIDTH-1:0]               wr_count,
  output logic [CNT_WIDTH-1:0]               rd_count,
  output logic                               err,
  output logic [3:0]                         err_code
);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] MAX_OCC = OCC_W'(MAX_OUTSTANDING);

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, rlast_hs;
  assign aw_hs    = monitor.awvalid && monitor.awready;
  assign w_hs     = monitor.wvalid  && monitor.wready;
  assign b_hs     = monitor.bvalid  && monitor.bready;
  assign ar_hs    = monitor.arvalid && monitor.arready;
  assign r_hs     = monitor.rvalid  && monitor.rready;
  assign rlast_hs = r_hs && monitor.rlast;

  // Payload fields the checker does not inspect.
  logic [AXI4_ADDRESS_WIDTH-1:0] unused_awaddr, unused_araddr;
  logic [AXI4_DATA_WIDTH-1:0]    unused_wdata, unused_rdata;
  logic [AXI4_ID_WIDTH-1:0]      unused_ids;
  logic                          unused_misc;
  assign unused_awaddr = monitor.awaddr;
  assign unused_araddr = monitor.araddr;
  assign unused_wdata  = monitor.wdata;
  assign unused_rdata  = monitor.rdata;
  assign unused_ids    = monitor.awid ^ monitor.bid ^ monitor.arid ^ monitor.rid;
  assign unused_misc   = ^{monitor.wstrb, monitor.bresp, monitor.arlen, monitor.rresp};

  // AW length FIFO and write-side tracking state
  logic [7:0]       len_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [OCC_W-1:0] fifo_occ;
  logic [7:0]       beat_cnt;
  logic [OCC_W-1:0] credit;

  logic       fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [7:0] head_len, beat_next;
  logic       w_err3, w_err4, w_err7;

  assign fifo_full  = (fifo_occ == MAX_OCC);
  assign fifo_empty = (fifo_occ == '0);
  assign head_len   = len_mem[rd_ptr];

  // W beat check against the AWLEN at the FIFO head; decides pop and beat index
  always_comb begin
    fifo_push = aw_hs && !fifo_full;
    fifo_pop  = 1'b0;
    beat_next = beat_cnt;
    w_err3    = 1'b0;
    w_err4    = 1'b0;
    w_err7    = 1'b0;
    if (w_hs) begin
      if (fifo_empty) begin
        w_err7 = 1'b1;
      end else if (monitor.wlast) begin
        fifo_pop  = 1'b1;
        beat_next = 8'd0;
        w_err3    = (beat_cnt < head_len);
      end else if (beat_cnt >= head_len) begin
        // Missing WLAST: close the burst anyway so tracking stays aligned.
        fifo_pop  = 1'b1;
        beat_next = 8'd0;
        w_err4    = 1'b1;
      end else begin
        beat_next = beat_cnt + 8'd1;
      end
    end
  end

  // AW length storage (no reset needed: occupancy qualifies every entry)
  always_ff @(posedge clk) begin
    if (fifo_push) len_mem[wr_ptr] <= monitor.awlen;
  end

  // FIFO pointers, occupancy and W beat counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_occ <= '0;
      beat_cnt <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (fifo_push && !fifo_pop)      fifo_occ <= fifo_occ + 1'b1;
      else if (fifo_pop && !fifo_push) fifo_occ <= fifo_occ - 1'b1;
      beat_cnt <= beat_next;
    end
  end

  // Outstanding counters and completed-burst credit, saturating at both ends
  logic wr_inc, wr_dec, rd_inc, rd_dec, cr_inc, cr_dec;
  assign wr_dec = b_hs && (wr_outstanding != '0);
  assign wr_inc = aw_hs && ((wr_outstanding != MAX_OCC) || wr_dec);
  assign rd_dec = rlast_hs && (rd_outstanding != '0);
  assign rd_inc = ar_hs && ((rd_outstanding != MAX_OCC) || rd_dec);
  assign cr_dec = b_hs && (credit != '0);
  assign cr_inc = fifo_pop && ((credit != MAX_OCC) || cr_dec);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_outstanding <= '0;
      rd_outstanding <= '0;
      credit         <= '0;
    end else begin
      if (wr_inc && !wr_dec)      wr_outstanding <= wr_outstanding + 1'b1;
      else if (wr_dec && !wr_inc) wr_outstanding <= wr_outstanding - 1'b1;
      if (rd_inc && !rd_dec)      rd_outstanding <= rd_outstanding + 1'b1;
      else if (rd_dec && !rd_inc) rd_outstanding <= rd_outstanding - 1'b1;
      if (cr_inc && !cr_dec)      credit <= credit + 1'b1;
      else if (cr_dec && !cr_inc) credit <= credit - 1'b1;
    end
  end

  logic timeout;
`ifdef AXI4_TXN_MONITOR_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);
  logic [WD_W-1:0] wdog;
  logic            busy;
  assign busy    = (wr_outstanding != '0) || (rd_outstanding != '0);
  assign timeout = (wdog == WD_MAX);

  // Watchdog: counts idle cycles while work is outstanding, holds at the limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           wdog <= '0;
    else if (b_hs || r_hs || !busy)    wdog <= '0;
    else if (wdog != WD_MAX)           wdog <= wdog + 1'b1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign timeout        = 1'b0;
`endif

  // Error detection; lowest code wins when several fire in one cycle
  logic       err_hit;
  logic [3:0] err_det;
  always_comb begin
    err_hit = 1'b1;
    err_det = 4'd0;
    if (aw_hs && fifo_full)                       err_det = 4'd1;
    else if (ar_hs && rd_outstanding == MAX_OCC)  err_det = 4'd2;
    else if (w_err3)                              err_det = 4'd3;
    else if (w_err4)                              err_det = 4'd4;
    else if (b_hs && credit == '0)                err_det = 4'd5;
    else if (r_hs && rd_outstanding == '0)        err_det = 4'd6;
    else if (w_err7)                              err_det = 4'd7;
    else if (timeout)                             err_det = 4'd8;
    else                                          err_hit = 1'b0;
  end

  // Sticky first-error capture; an error in the clr cycle lands after the clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err      <= 1'b0;
      err_code <= 4'd0;
    end else begin
      if (clr) begin
        err      <= 1'b0;
        err_code <= 4'd0;
      end
      if (err_hit && (!err || clr)) begin
        err      <= 1'b1;
        err_code <= err_det;
      end
    end
  end

  // Completed-transaction counters, wrapping naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_count <= '0;
      rd_count <= '0;
    end else if (clr) begin
      wr_count <= '0;
      rd_count <= '0;
    end else begin
      if (b_hs)     wr_count <= wr_count + 1'b1;
      if (rlast_hs) rd_count <= rd_count + 1'b1;
    end
  end
endmodule

// File: doc/axi4_txn_monitor.md
# axi4_txn_monitor

Passive AXI4 transaction monitor and protocol checker attached to an `axi4_if.monitor` modport. It never drives the bus. It tracks outstanding read and write bursts, counts completed transactions, checks burst-length/LAST consistency, and captures the first protocol violation in a sticky error register. It sits beside any interconnect port or BFM link as a bench or in-silicon debug observer.

## Interface
- `AXI4_ADDRESS_WIDTH`, default 32: address width of the monitored interface.
- `AXI4_DATA_WIDTH`, default 32: data width of the monitored interface.
- `AXI4_ID_WIDTH`, default 4: ID width of the monitored interface.
- `MAX_OUTSTANDING`, default 8: tracking depth per direction. Power of 2, at least 2.
- `CNT_WIDTH`, default 32: width of the completed-transaction counters.
- `TIMEOUT_CYCLES`, default 1024: watchdog limit. Used only with `AXI4_TXN_MONITOR_TIMEOUT_EN`.
- `clk`  input  1: clock; all logic is on the rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `monitor`  modport  `axi4_if.monitor`: observed bus, all inputs.
- `clr`  input  1: synchronous clear of counters and the error register. Tracking state is untouched.
- `wr_outstanding`  output  $clog2(MAX_OUTSTANDING)+1: accepted AW not yet answered by B.
- `rd_outstanding`  output  $clog2(MAX_OUTSTANDING)+1: accepted AR not yet finished by R with RLAST.
- `wr_count`  output  CNT_WIDTH: B handshakes seen.
- `rd_count`  output  CNT_WIDTH: R handshakes seen with RLAST=1.
- `err`  output  1: sticky error flag.
- `err_code`  output  4: code of the first error; 0 means no error.

## Operation
- Handshake means VALID && READY sampled at a rising edge.
- **AW tracking:** each AW handshake pushes AWLEN into an AW length FIFO of depth MAX_OUTSTANDING and increments `wr_outstanding`.
- **W tracking:** the W beat counter compares each W handshake with the AWLEN at the FIFO head.
  - On WLAST, the head is popped and the beat counter returns to 0.
  - The monitor requires AW-first ordering. A W handshake while the AW FIFO is empty is an error.
- **B tracking:** increments the completed-burst credit. Each B handshake consumes one credit, decrements `wr_outstanding` and increments `wr_count`.
- **R tracking:** an AR handshake increments `rd_outstanding`. An R handshake with RLAST decrements it and increments `rd_count`. Per-ID length is not checked on R.
- **Error codes:** the first error wins and later errors never overwrite it.
  - 1: AW handshake while the AW FIFO is full.
  - 2: AR handshake while `rd_outstanding` equals MAX_OUTSTANDING.
  - 3: WLAST=1 on beat index < head AWLEN.
  - 4: WLAST=0 on beat index == head AWLEN.
  - 5: B handshake with zero completed-burst credit.
  - 6: R handshake while `rd_outstanding` is 0.
  - 7: W handshake while the AW FIFO is empty.
  - 8: timeout.
- **Erroring events still update tracking**, with saturation:
  - No push when full.
  - No decrement below 0.
  - Code 4 forces a pop, as if WLAST had been set.
- **Simultaneous events:**
  - A same-cycle push and pop leaves the FIFO occupancy unchanged.
  - A same-cycle AR and R-last leaves `rd_outstanding` unchanged.
  - A same-cycle W burst completion and B leave the credit unchanged.
- **clr:** zeroes `wr_count`, `rd_count`, `err` and `err_code`. If an error is detected in the same cycle as `clr`, that error is captured after the clear.
- **Counter wrap:** `wr_count` and `rd_count` wrap modulo 2^CNT_WIDTH.

## Timing
- All outputs are registered. Every output updates on the edge after the triggering handshake, so latency is 1 cycle.
- `err` is raised on the edge after the violating handshake.
- Reset values: all outputs are 0, the FIFO is empty, the beat counter is 0, the credit is 0 and the watchdog is 0.
- If `rst` asserts mid-burst, all in-flight tracking is discarded. No error is raised for bursts that straddle reset.

## Configuration
- Macro: `AXI4_TXN_MONITOR_TIMEOUT_EN`.
- **When defined:**
  - A watchdog counter increments on every cycle in which `wr_outstanding + rd_outstanding > 0` and no B or R handshake occurs.
  - The counter clears on any B or R handshake, or when nothing is outstanding.
  - When it reaches TIMEOUT_CYCLES, error code 8 is captured and the counter holds.
- **When undefined:** there is no watchdog logic and code 8 is never produced.

## Test plan
- AWLEN=3, four W beats with WLAST on the 4th, one B → `wr_outstanding` goes 1 then 0, `wr_count`=1, `err`=0.
- AWLEN=3, WLAST on the 2nd beat → `err`=1, `err_code`=3 the cycle after that beat. A subsequent R with no AR leaves `err_code` at 3.
- 8 AR handshakes with MAX_OUTSTANDING=8, then a 9th → `rd_outstanding`=8 and `err_code`=2. Then 8 RLAST beats → `rd_outstanding`=0 and `rd_count`=8.
- AR and R-last in the same cycle with `rd_outstanding`=2 → stays 2 and `rd_count` increments by 1.
- B with no prior W burst → `err_code`=5. Pulse `clr` → `err`=0 and counters 0. Then an R with nothing outstanding in the same cycle as `clr` → `err_code`=6.
- With the macro defined and TIMEOUT_CYCLES=16: one AR, then no R for 16 cycles → `err_code`=8. Without the macro, the same stimulus leaves `err`=0.
